// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler
// Shares one external pipelined unsigned multiplier among N requesters.
// A round-robin arbiter issues at most one operation per cycle. A tag pipeline
// that runs in step with the multiplier routes each product back to the
// requester that issued it. Each requester may have only one operation
// outstanding: it is marked pending from acceptance until its result is consumed.

module mult_rr_scheduler #(
  parameter int N    = 4,
  parameter int SIZE = 8,
  parameter int LAT  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N-1:0]          i_req_valid,
  output logic [N-1:0]          o_req_ready,
  input  logic [N*SIZE-1:0]     i_req_a,
  input  logic [N*SIZE-1:0]     i_req_b,
  output logic [N-1:0]          o_rsp_valid,
  input  logic [N-1:0]          i_rsp_ready,
  output logic [N*2*SIZE-1:0]   o_rsp_data,
  output logic [SIZE-1:0]       o_mul_a,
  output logic [SIZE-1:0]       o_mul_b,
  input  logic [2*SIZE-1:0]     i_mul_out,
  output logic                  o_busy
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  typedef logic [IDW-1:0] id_t;

  // Round-robin pointer and one pending flag per requester
  id_t               r_ptr;
  logic [N-1:0]      r_pend;

  // Registered operands driven to the multiplier
  logic [SIZE-1:0]   r_mul_a;
  logic [SIZE-1:0]   r_mul_b;

  // Tag pipeline. Stage 0 is loaded on the same edge as the operand registers.
  // Stage LAT therefore lines up with the product on i_mul_out.
  logic              r_tag_valid [0:LAT];
  id_t               r_tag_id    [0:LAT];

  // Held responses
  logic [N-1:0]      r_rsp_valid;
  logic [2*SIZE-1:0] r_rsp_data  [N];

  // Arbitration results
  logic [N-1:0]      w_eligible;
  logic [N-1:0]      w_grant;
  logic              w_found;
  id_t               w_grant_id;
  id_t               w_ptr_next;
  logic [SIZE-1:0]   w_sel_a;
  logic [SIZE-1:0]   w_sel_b;
  logic [N-1:0]      w_rsp_fire;

  assign w_eligible = i_req_valid & ~r_pend;
  assign w_rsp_fire = r_rsp_valid & i_rsp_ready;

  // Scan eligible requesters starting at the pointer and grant the first one found
  always_comb begin : arb_comb
    int   scanIdx;
    id_t  scanId;
    w_grant    = '0;
    w_found    = 1'b0;
    w_grant_id = '0;
    scanIdx    = 0;
    scanId     = '0;
    for (int k = 0; k < N; k++) begin
      scanIdx = (int'(r_ptr) + k) % N;
      scanId  = id_t'(scanIdx);
      if (!w_found && w_eligible[scanId]) begin
        w_found         = 1'b1;
        w_grant_id      = scanId;
        w_grant[scanId] = 1'b1;
      end
    end
  end

  // Select the winner's operands and work out where the pointer moves after a grant
  always_comb begin
    w_sel_a    = i_req_a[w_grant_id*SIZE +: SIZE];
    w_sel_b    = i_req_b[w_grant_id*SIZE +: SIZE];
    w_ptr_next = (w_grant_id == id_t'(N-1)) ? '0 : w_grant_id + id_t'(1);
  end

  // Grants are suppressed while reset is held so no handshake is seen during reset
  assign o_req_ready = i_rst_n ? w_grant : '0;

  // Operand issue register and round-robin pointer; idle cycles drive zero operands
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr   <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else begin
      r_mul_a <= w_found ? w_sel_a : '0;
      r_mul_b <= w_found ? w_sel_b : '0;
      if (w_found) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  // Tag pipeline: no stall; products arriving with an invalid tag are ignored
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s <= LAT; s++) begin
        r_tag_valid[s] <= 1'b0;
        r_tag_id[s]    <= '0;
      end
    end else begin
      r_tag_valid[0] <= w_found;
      r_tag_id[0]    <= w_grant_id;
      for (int s = 1; s <= LAT; s++) begin
        r_tag_valid[s] <= r_tag_valid[s-1];
        r_tag_id[s]    <= r_tag_id[s-1];
      end
    end
  end

  // Pending flags: set on accept, cleared when the held result is consumed
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend | (w_found ? w_grant : '0)) & ~w_rsp_fire;
    end
  end

  // Capture the returning product into the issuing requester's slot and hold it until consumed
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= '0;
      for (int i = 0; i < N; i++) begin
        r_rsp_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_rsp_fire[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
      if (r_tag_valid[LAT]) begin
        r_rsp_valid[r_tag_id[LAT]] <= 1'b1;
        r_rsp_data[r_tag_id[LAT]]  <= i_mul_out;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_rsp_pack
      assign o_rsp_data[g*2*SIZE +: 2*SIZE] = r_rsp_data[g];
    end
  endgenerate

  assign o_rsp_valid = r_rsp_valid;
  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;
  assign o_busy      = |r_pend;

endmodule
